// File: rtl/regbank_writeback.sv
// regbank_writeback: producer side of the register bank's single write port.
// Merges single-cycle ALU results and handshaked memory results (through a
// small FIFO) onto one registered write port. It also tracks outstanding
// multi-cycle writes per register and raises a decode stall on hazards.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   alu_we/alu_addr/alu_data     ALU result, no backpressure
//   mem_valid/mem_ready          memory result handshake
//   mem_addr/mem_data            memory result payload
//   issue_valid/issue_addr       multi-cycle op issued, sets pending bit
//   chk_addr_a/chk_addr_b        decode operands checked against pending
//   stall                        combinational operand hazard
//   addr_d/data_d/we             registered register bank write port
module regbank_writeback #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned NREGS      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [3:0]  issue_addr,
    input  logic [3:0]  chk_addr_a,
    input  logic [3:0]  chk_addr_b,
    output logic        stall,
    output logic [3:0]  addr_d,
    output logic [31:0] data_d,
    output logic        we
);

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [AW-1:0]    q_addr [FIFO_DEPTH];
    logic [DW-1:0]    q_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;

    logic alu_sel;
    logic fifo_empty;
    logic handshake;
    logic do_pop;
    logic do_bypass;
    logic do_push;

    // Ready depends only on the registered count, so a same-cycle pop does not free a slot.
    assign mem_ready = (count != CNT_W'(FIFO_DEPTH));

    assign stall = ((chk_addr_a != '0) && pending[chk_addr_a]) ||
                   ((chk_addr_b != '0) && pending[chk_addr_b]);

    // Write-source arbitration: ALU, then FIFO head, then direct bypass.
    always_comb begin
        alu_sel    = alu_we && (alu_addr != '0);
        fifo_empty = (count == '0);
        handshake  = mem_valid && mem_ready;
        do_pop     = !alu_sel && !fifo_empty;
        do_bypass  = !alu_sel && fifo_empty && handshake && (mem_addr != '0);
        // Register-0 results complete the handshake but are dropped.
        do_push    = handshake && (mem_addr != '0) && !do_bypass;
    end

    // Scoreboard update; a same-edge issue overrides the clear.
    always_comb begin
        pending_next = pending;
        if (do_pop) begin
            pending_next[q_addr[rd_ptr]] = 1'b0;
        end
        if (do_bypass) begin
            pending_next[mem_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            we      <= 1'b0;
            addr_d  <= '0;
            data_d  <= '0;
            pending <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            pending <= pending_next;
            we      <= alu_sel || do_pop || do_bypass;
            if (alu_sel) begin
                addr_d <= alu_addr;
                data_d <= alu_data;
            end else if (do_pop) begin
                addr_d <= q_addr[rd_ptr];
                data_d <= q_data[rd_ptr];
            end else if (do_bypass) begin
                addr_d <= mem_addr;
                data_d <= mem_data;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            q_addr[wr_ptr] <= mem_addr;
            q_data[wr_ptr] <= mem_data;
        end
    end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
- Producer side of the CPU register bank's single write port. Merges writes from two sources onto one registered addr_d/data_d/we output:
  - the single-cycle ALU path;
  - the multi-cycle memory/load path, which uses a valid/ready handshake and a small FIFO.
- Keeps a per-register pending scoreboard for issued multi-cycle ops and raises a stall for the decode stage when an operand register has a write still outstanding.

Parameters:
- FIFO_DEPTH, 2, depth of the memory-result queue; power of 2, minimum 2.
- NREGS, 16, number of architectural registers. Register 0 is hardwired zero and is never written.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_we  in  1  ALU result valid this cycle; no backpressure
- alu_addr  in  4  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  memory result accepted when mem_valid && mem_ready
- mem_addr  in  4  memory result destination register
- mem_data  in  32  memory result
- issue_valid  in  1  a multi-cycle op was issued this cycle
- issue_addr  in  4  destination register of the issued op
- chk_addr_a  in  4  decode operand A register
- chk_addr_b  in  4  decode operand B register
- stall  out  1  operand has an outstanding write
- addr_d  out  4  register bank write address
- data_d  out  32  register bank write data
- we  out  1  register bank write enable

Behaviour:
- Reset values: we=0, addr_d=0, data_d=0, pending=0, FIFO empty, count=0, so mem_ready=1 in the first cycle after reset.
- Reset mid-operation: FIFO contents and pending bits are discarded; we=0 in the cycle after the reset edge.
- addr_d, data_d and we are registered. Exactly one write per cycle at most.
- Write selection at each edge, in priority order:
  1. ALU: alu_we && alu_addr!=0.
  2. FIFO head: FIFO not empty; the head is popped.
  3. Bypass: FIFO empty, the memory handshake fires, and mem_addr!=0. The value is written directly and not enqueued.
  4. Otherwise: we=0. addr_d and data_d hold their previous values.
- Latency:
  - ALU result appears on we/addr_d/data_d 1 cycle after alu_we.
  - Memory result appears 1 cycle after the handshake when uncontended.
  - Under contention, each ALU write delays the FIFO by 1 cycle.
- Enqueue: on a handshake that is not bypassed, the result is pushed to the FIFO tail. Push and pop in the same cycle is legal.
- Memory results are written strictly in acceptance order.
- mem_ready = (count != FIFO_DEPTH), derived from the registered count only; a same-cycle pop does not raise it. When full, mem_ready=0 until after an edge at which a pop occurs.
- Writes to register 0:
  - alu_addr==0: ignored, consumes no write slot.
  - mem_addr==0: the handshake completes, the data is dropped, nothing is enqueued.
- Scoreboard pending[NREGS-1:0]:
  - Set: pending[issue_addr] is set at the edge after issue_valid && issue_addr!=0.
  - Clear: pending[addr] is cleared at the same edge that registers a memory-sourced write to addr (FIFO pop or bypass).
  - Simultaneous set and clear of the same register: set wins.
  - ALU writes never change pending.
- Protocol and hazards:
  - Issuing to a register that is already pending is a protocol violation, prevented by the issuer obeying stall.
  - An ALU write to a pending register is allowed and is not blocked here.
- stall is combinational: (chk_addr_a!=0 && pending[chk_addr_a]) || (chk_addr_b!=0 && pending[chk_addr_b]).
  - stall deasserts in the cycle that we carries the write. The register bank forwards data_d to a same-cycle read of addr_d, so the released operand is correct.

Test Plan:
- Reset, then alu_we=1, alu_addr=3, alu_data=0x12345678 for 1 cycle -> next cycle we=1, addr_d=3, data_d=0x12345678; following cycle we=0.
- FIFO empty, mem_valid=1, mem_addr=5, mem_data=0xAA, alu_we=0 -> mem_ready=1; next cycle we=1, addr_d=5, data_d=0xAA (bypass); FIFO remains empty.
- alu_we held 1 (addr 1) for 4 cycles while mem offers 0x10→r6, 0x20→r7, 0x30→r8:
  - mem_ready drops after 2 accepts (FIFO_DEPTH=2);
  - 4 ALU writes emerge first, then r6=0x10 and r7=0x20;
  - r8 is accepted only after the first pop edge and is written 0x30 last.
- issue_valid with issue_addr=9, then chk_addr_a=9 -> stall=1 from the next cycle; load result for r9 arrives -> stall=0 in the same cycle we=1, addr_d=9.
- Same-cycle issue_addr=4 and FIFO pop writing r4 -> pending[4] remains 1; stall with chk_addr_b=4 stays 1.
- Edge and reset cases:
  - mem_addr=0 with mem_valid=1 -> accepted, we stays 0.
  - issue_addr=0 -> no pending bit set.
  - Reset asserted with 2 entries queued -> we=0 and mem_ready=1 after the reset edge; queued data is never written.
